carton_packer: RTL

Downstream stage of the pill-bottling controller. It consumes the per-bottle "bottle changed" pulse and that bottle's pill count, groups finished bottles into cartons of a fixed size, and hands each full carton to the conveyor over a req/ack handshake. While a carton is waiting for the conveyor, it back-pressures the filler with `stall`. It also keeps a carton tally and a per-carton pill sum for the seven-segment display path.

---
 rtl/carton_pkg.sv | 27 ++
 rtl/carton_packer_ack_watchdog.sv | 32 +++
 rtl/carton_packer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/carton_pkg.sv
// carton_pkg: shared definitions for the carton packer.
// State encodings, pill limits, sum widths and small pill helpers.
package carton_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_HANDOFF = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam int MAX_PILLS    = 20;
  localparam int PILL_W       = 5;
  localparam int PILL_SUM_W   = 10;
  localparam int BOTTLE_CNT_W = 4;

  // A bottle count is usable only when it is in 1..MAX_PILLS.
  function automatic logic pills_valid(input logic [PILL_W-1:0] p);
    return (p != '0) && (p <= PILL_W'(MAX_PILLS));
  endfunction

  // Zero-extend a bottle count to the carton sum width.
  function automatic logic [PILL_SUM_W-1:0] pills_ext(input logic [PILL_W-1:0] p);
    return {{(PILL_SUM_W - PILL_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/carton_packer_ack_watchdog.sv
// ack_watchdog: counts cycles spent waiting for the conveyor ack.
// Present only in builds with CARTON_TIMEOUT_EN defined.
// expired is high during the ACK_TIMEOUT-th consecutive cycle of start.
`ifdef CARTON_TIMEOUT_EN
module ack_watchdog #(
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic clock,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int              CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count waiting cycles; hold at the last value until cleared.
  always_ff @(posedge clock) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (start && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = start && (cnt == LAST);

endmodule
`endif

// File: rtl/carton_packer.sv
// carton_packer: groups finished bottles into cartons and hands each full
// carton to the conveyor over a req/ack handshake, stalling the filler while
// a carton waits. Optional feature macro: CARTON_TIMEOUT_EN (ack watchdog
// that faults the block when the conveyor does not answer in ACK_TIMEOUT
// cycles). Reset is synchronous, active-low.
module carton_packer
  import carton_pkg::*;
#(
  parameter int BOTTLES_PER_CARTON = 6,
  parameter int CARTON_W           = 8,
  parameter int ACK_TIMEOUT        = 1000
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    bottle_done,
  input  logic [PILL_W-1:0]       bottle_pills,
  input  logic                    carton_ack,
  output logic                    carton_req,
  output logic                    stall,
  output logic [BOTTLE_CNT_W-1:0] bottle_cnt,
  output logic [CARTON_W-1:0]     carton_cnt,
  output logic [PILL_SUM_W-1:0]   carton_pills,
  output logic [PILL_SUM_W-1:0]   last_pills,
  output logic                    err
);

  localparam logic [BOTTLE_CNT_W-1:0] FULL_CNT = BOTTLE_CNT_W'(BOTTLES_PER_CARTON);

  // Reject illegal configurations at elaboration time.
  if (BOTTLES_PER_CARTON < 1 || BOTTLES_PER_CARTON > 15) begin : g_bad_bpc
    $error("carton_packer: BOTTLES_PER_CARTON must be 1..15");
  end
  if (ACK_TIMEOUT < 2) begin : g_bad_timeout
    $error("carton_packer: ACK_TIMEOUT must be >= 2");
  end

  state_e                  state;
  logic                    pend_vld;
  logic [PILL_W-1:0]       pend_pills;
  logic                    good_pulse;
  logic                    bad_pulse;
  logic                    wd_expired;
  logic [BOTTLE_CNT_W-1:0] bottle_cnt_nxt;
  logic [PILL_W-1:0]       seed_pills;

  assign good_pulse     = bottle_done && pills_valid(bottle_pills);
  assign bad_pulse      = bottle_done && !pills_valid(bottle_pills);
  assign bottle_cnt_nxt = bottle_cnt + BOTTLE_CNT_W'(1);
  // A bottle arriving with the ack seeds the next carton; otherwise the
  // pending one does (both together is a fault and never reaches here).
  assign seed_pills     = good_pulse ? bottle_pills : pend_pills;

`ifdef CARTON_TIMEOUT_EN
  logic wd_clear;
  logic wd_start;

  assign wd_start = (state == ST_HANDOFF);
  assign wd_clear = (state != ST_HANDOFF) || carton_ack;

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clock  (clock),
    .rst    (rst),
    .start  (wd_start),
    .clear  (wd_clear),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // Carton FSM with all outputs registered alongside the state.
  // NOTE: every register here uses <= so all updates read the pre-edge
  // values; a later <= to the same register in one pass overrides an
  // earlier default, which is how the fault branch wins over the err pulse.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state        <= ST_IDLE;
      carton_req   <= 1'b0;
      stall        <= 1'b0;
      bottle_cnt   <= '0;
      carton_cnt   <= '0;
      carton_pills <= '0;
      last_pills   <= '0;
      err          <= 1'b0;
      pend_vld     <= 1'b0;
      pend_pills   <= '0;
    end else if (!en) begin
      state        <= ST_IDLE;
      carton_req   <= 1'b0;
      stall        <= 1'b0;
      bottle_cnt   <= '0;
      carton_pills <= '0;
      err          <= 1'b0;
      pend_vld     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_FILL;
        end

        ST_FILL: begin
          err <= bad_pulse;
          if (good_pulse) begin
            bottle_cnt   <= bottle_cnt_nxt;
            carton_pills <= carton_pills + pills_ext(bottle_pills);
            if (bottle_cnt_nxt == FULL_CNT) begin
              state      <= ST_HANDOFF;
              carton_req <= 1'b1;
              stall      <= 1'b1;
            end
          end
        end

        ST_HANDOFF: begin
          err <= bad_pulse;
          if (good_pulse && pend_vld) begin
            state      <= ST_FAULT;
            carton_req <= 1'b0;
            stall      <= 1'b1;
            err        <= 1'b1;
            pend_vld   <= 1'b0;
          end else if (carton_ack) begin
            last_pills <= carton_pills;
            if (carton_cnt != '1) begin
              carton_cnt <= carton_cnt + CARTON_W'(1);
            end
            pend_vld <= 1'b0;
            if (good_pulse || pend_vld) begin
              bottle_cnt   <= BOTTLE_CNT_W'(1);
              carton_pills <= pills_ext(seed_pills);
              if (FULL_CNT == BOTTLE_CNT_W'(1)) begin
                state      <= ST_HANDOFF;
                carton_req <= 1'b1;
                stall      <= 1'b1;
              end else begin
                state      <= ST_FILL;
                carton_req <= 1'b0;
                stall      <= 1'b0;
              end
            end else begin
              bottle_cnt   <= '0;
              carton_pills <= '0;
              state        <= ST_FILL;
              carton_req   <= 1'b0;
              stall        <= 1'b0;
            end
          end else if (wd_expired) begin
            state      <= ST_FAULT;
            carton_req <= 1'b0;
            stall      <= 1'b1;
            err        <= 1'b1;
            pend_vld   <= 1'b0;
          end else if (good_pulse) begin
            pend_vld   <= 1'b1;
            pend_pills <= bottle_pills;
          end
        end

        ST_FAULT: begin
          carton_req <= 1'b0;
          stall      <= 1'b1;
          err        <= 1'b1;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
